// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of one shared add/sub datapath with a registered result.
// Optional: define ADDSUB_ARB_OVF_EN to add the registered signed-overflow output res_ovf.
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_m,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_m,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
`ifdef ADDSUB_ARB_OVF_EN
  output logic             res_ovf,
`endif
  output logic             dbg_state
);

  // Handshake: a request transfers in any cycle where reqN_valid and reqN_ready are both 1;
  // the result transfers where res_valid and res_ready are both 1. reqN_ready never depends on
  // anything but the current state, valids, res_ready and rst_n, and never waits on itself.

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, next_state;
  logic             last_grant;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] op_a, op_b, b_x;
  logic             op_m;
  logic [WIDTH:0]   full;

  // Round-robin: on a tie the requester that did not win last time is chosen.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
  end

  assign accept = rst_n && (req0_valid || req1_valid) &&
                  ((state == IDLE) || res_ready);

  always_comb begin
    op_a = grant_id ? req1_a : req0_a;
    op_b = grant_id ? req1_b : req0_b;
    op_m = grant_id ? req1_m : req0_m;
  end

  assign b_x  = op_b ^ {WIDTH{op_m}};
  assign full = {1'b0, op_a} + {1'b0, b_x} + {{WIDTH{1'b0}}, op_m};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    if (accept)                         next_state = HOLD;
    else if (state == HOLD && res_ready) next_state = IDLE;
  end

  // Output logic
  always_comb begin
    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;
    res_valid  = (state == HOLD);
    dbg_state  = state;
  end

  // Result registers reload only on an accept, so they stay stable while held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      res_id     <= 1'b0;
      res_sum    <= '0;
      res_carry  <= 1'b0;
    end else if (accept) begin
      last_grant <= grant_id;
      res_id     <= grant_id;
      res_sum    <= full[WIDTH-1:0];
      res_carry  <= full[WIDTH];
    end
  end

`ifdef ADDSUB_ARB_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      res_ovf <= 1'b0;
    else if (accept)
      res_ovf <= (op_a[WIDTH-1] == b_x[WIDTH-1]) && (full[WIDTH-1] != op_a[WIDTH-1]);
  end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed steps then randomized traffic against an
// arithmetic reference model with an expected-result queue.
module tb_addsub_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_m, req1_m;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_ready, res_id, res_carry;
  logic [W-1:0] res_sum;
  logic         dbg_state;
`ifdef ADDSUB_ARB_OVF_EN
  logic         res_ovf;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
    .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .res_carry(res_carry),
`ifdef ADDSUB_ARB_OVF_EN
    .res_ovf(res_ovf),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: entries are {ovf, id, carry, sum}
  logic [W+2:0] exp_q[$];
  logic         m_last;
  logic         just_reset;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result computed with plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic m, input logic id);
    int ia, ib, r, sa, sb, sr;
    logic [W-1:0] s;
    logic c, o;
    ia = int'(a);
    ib = int'(b);
    r  = m ? ia - ib : ia + ib;
    s  = W'(r & ((1 << W) - 1));
    c  = m ? (ia >= ib) : (r >= (1 << W));
    sa = (ia >= (1 << (W-1))) ? ia - (1 << W) : ia;
    sb = (ib >= (1 << (W-1))) ? ib - (1 << W) : ib;
    sr = m ? sa - sb : sa + sb;
    o  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return {o, id, c, s};
  endfunction

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic cycle();
    logic any, g, exp_r0, exp_r1, acc;
    logic [W+2:0] f;
    #2;
    any    = req0_valid || req1_valid;
    g      = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    acc    = rst_n && any && ((exp_q.size() == 0) || res_ready);
    exp_r0 = acc && !g;
    exp_r1 = acc && g;
    check("req0_ready", req0_ready, exp_r0);
    check("req1_ready", req1_ready, exp_r1);
    check("res_valid", res_valid, exp_q.size() > 0);
    if (just_reset) begin
      check("rst_sum", res_sum, 0);
      check("rst_carry", res_carry, 0);
      check("rst_id", res_id, 0);
`ifdef ADDSUB_ARB_OVF_EN
      check("rst_ovf", res_ovf, 0);
`endif
    end
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      check("res_sum", res_sum, f[W-1:0]);
      check("res_carry", res_carry, f[W]);
      check("res_id", res_id, f[W+1]);
`ifdef ADDSUB_ARB_OVF_EN
      check("res_ovf", res_ovf, f[W+2]);
`endif
    end
    if (!rst_n) begin
      exp_q.delete();
      m_last = 1'b1;
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (exp_q.size() > 0 && res_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(g ? model(req1_a, req1_b, req1_m, 1'b1)
                          : model(req0_a, req0_b, req0_m, 1'b0));
        m_last = g;
      end
    end
    @(posedge clk);
    #1;
    if (acc && !g) req0_valid = 1'b0;
    if (acc && g)  req1_valid = 1'b0;
  endtask

  // Driver tasks
  task automatic drive0(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_m = m;
  endtask

  task automatic drive1(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_m = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_m = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_m = 1'b0;
    exp_q.delete(); m_last = 1'b1; just_reset = 1'b0;
    @(posedge clk); #1;
    just_reset = 1'b1;

    // Reset with requests present: readies must stay low.
    drive0(4'd3, 4'd4, 1'b0);
    drive1(4'd5, 4'd6, 1'b1);
    do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle();

    // Single request, subtract 9-5.
    res_ready = 1'b1;
    drive0(4'b1001, 4'b0101, 1'b1);
    cycle();
    #2;
    check("single_sum", res_sum, 4'b0100);
    check("single_carry", res_carry, 1'b1);
    check("single_id", res_id, 1'b0);
    cycle();
    cycle();

    // Tie after reset: req0 first, then req1 back-to-back.
    do_reset();
    res_ready = 1'b1;
    drive0(4'b1100, 4'b1100, 1'b0);
    drive1(4'b0100, 4'b1001, 1'b0);
    cycle();
    #2;
    check("tie_first_id", res_id, 1'b0);
    check("tie_first_sum", res_sum, 4'b1000);
    cycle();
    #2;
    check("tie_second_id", res_id, 1'b1);
    check("tie_second_sum", res_sum, 4'b1101);
    check("tie_second_carry", res_carry, 1'b0);
    cycle();

    // Back-pressure for 5 cycles with a pending request, then release.
    res_ready = 1'b0;
    drive0(4'd7, 4'd2, 1'b0);
    cycle();
    drive1(4'd1, 4'd3, 1'b1);
    for (int i = 0; i < 5; i++) cycle();
    res_ready = 1'b1;
    cycle();
    cycle();

    // Subtraction borrow and signed overflow.
    drive0(4'b0000, 4'b1111, 1'b1);
    cycle();
    #2;
    check("borrow_sum", res_sum, 4'b0001);
    check("borrow_carry", res_carry, 1'b0);
    drive1(4'b0111, 4'b0001, 1'b0);
    cycle();
    #2;
    check("ovf_sum", res_sum, 4'b1000);
`ifdef ADDSUB_ARB_OVF_EN
    check("ovf_flag", res_ovf, 1'b1);
`endif
    cycle();

    // Reset while holding a result, then a tie must go to req0.
    res_ready = 1'b0;
    drive1(4'd9, 4'd9, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #2;
    check("hold_rst_valid", res_valid, 1'b0);
    check("hold_rst_sum", res_sum, 4'b0000);
    drive0(4'd1, 4'd1, 1'b0);
    drive1(4'd2, 4'd2, 1'b0);
    cycle();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Randomized traffic; a pending request stays stable until accepted.
    for (int i = 0; i < 300; i++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0)
        drive0(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if (!req1_valid && $urandom_range(0, 2) != 0)
        drive1(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      res_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 49) != 0);
      cycle();
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each: requester has an operation pending.
REQ-005 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH each: operands A and B.
REQ-006 The block SHALL have ports req0_m / req1_m, input, 1 each: mode; 0 = A+B, 1 = A-B.
REQ-007 The block SHALL have ports req0_ready / req1_ready, output, 1 each: operation accepted this cycle.
REQ-008 The block SHALL have port res_valid, output, 1: result registers hold a valid result.
REQ-009 The block SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-010 The block SHALL have port res_id, output, 1: index of the requester that owns the result.
REQ-011 The block SHALL have ports res_sum (output, WIDTH) and res_carry (output, 1): the result.

Function
REQ-012 The block SHALL contain one shared add/sub datapath: {carry,sum} = A + (B XOR {WIDTH{M}}) + M; for subtraction carry=1 means no borrow.
REQ-013 The FSM SHALL have states IDLE (no result held) and HOLD (result held, res_valid=1).
REQ-014 IDLE: when any reqN_valid=1, the block SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, compute, register the result and move to HOLD.
REQ-015 The result latency SHALL be 1 cycle: an accept in cycle N gives res_valid=1 in cycle N+1.
REQ-016 HOLD: res_sum, res_carry and res_id SHALL stay stable while res_ready=0, and both reqN_ready SHALL be 0.
REQ-017 HOLD with res_ready=1: if a request is pending, the block SHALL accept it in the same cycle and reload the result registers (back-to-back, res_valid stays 1); otherwise it SHALL go to IDLE.
REQ-018 Arbitration SHALL be round-robin: a 1-bit last_grant register; with both valid, grant the requester != last_grant; with one valid, grant it; last_grant updates only on an accept.
REQ-019 A reqN_ready SHALL never be 1 when reqN_valid=0, and at most one reqN_ready SHALL be 1 per cycle.
REQ-020 Sum overflow SHALL wrap modulo 2^WIDTH, with carry out on res_carry.

Reset
REQ-021 With rst_n=0 at a rising edge the block SHALL enter IDLE, set res_valid=0, res_sum=0, res_carry=0, res_id=0 and last_grant=1 (so req0 wins the first tie).
REQ-022 During reset, req0_ready and req1_ready SHALL be 0.
REQ-023 Reset asserted in HOLD SHALL discard the held result with no handshake.

Configuration
REQ-024 With macro ADDSUB_ARB_OVF_EN defined, the block SHALL add output res_ovf (1 bit, reset 0): registered two's-complement overflow, set when the operand sign bits (B after the XOR with M) match each other and differ from the sum MSB.
REQ-025 Without ADDSUB_ARB_OVF_EN, the port res_ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 After reset, req0 only: A=1001, B=0101, M=1 -> req0_ready=1 that cycle; next cycle res_valid=1, res_sum=0100, res_carry=1, res_id=0.
REQ-027 Both valid in the same cycle after reset: req0 A=1100,B=1100,M=0 and req1 A=0100,B=1001,M=0, res_ready=1 -> first result id 0, sum 1000, carry 1; next cycle id 1, sum 1101, carry 0.
REQ-028 res_ready=0 for 5 cycles with a result held -> res_* stable and both readies 0; release -> the pending request is accepted in the release cycle.
REQ-029 Subtraction borrow: A=0000, B=1111, M=1 -> sum 0001, carry 0; with ADDSUB_ARB_OVF_EN, A=0111, B=0001, M=0 -> sum 1000, res_ovf=1.
REQ-030 rst_n=0 asserted in HOLD -> next cycle res_valid=0, res_sum=0000, and the next tie is granted to req0.
